// File: rtl/e203_exu_rf_wbarb.sv
// Regfile writeback arbiter: ALU vs long-pipe, with ALU anti-starvation and an
// optional pending-write scoreboard built when E203_WBARB_SCOREBOARD_EN is defined.
module e203_exu_rf_wbarb #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int STARVE_LIM = 3
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  output logic               rf_wbck_o_ena,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  input  logic               disp_set_valid,
  input  logic [RFIDX_W-1:0] disp_set_idx,
  input  logic [RFIDX_W-1:0] dep_chk_idx1,
  input  logic [RFIDX_W-1:0] dep_chk_idx2,
  output logic               dep_hazard
);

  typedef struct packed {
    logic [RFIDX_W-1:0] rdidx;
    logic [XLEN-1:0]    wdat;
  } wb_t;

  localparam int CW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  logic [CW-1:0] starve_cnt;
  logic          conflict, starved, alu_win, longp_win;
  wb_t           grant;

  // Long-pipe normally wins a conflict; a starved ALU takes one grant back.
  assign conflict  = alu_wbck_i_valid & longp_wbck_i_valid;
  assign starved   = (starve_cnt == CW'(STARVE_LIM));
  assign alu_win   = alu_wbck_i_valid & (~longp_wbck_i_valid | starved);
  assign longp_win = longp_wbck_i_valid & ~alu_win;

  assign alu_wbck_i_ready   = alu_win;
  assign longp_wbck_i_ready = longp_win;

  always_comb begin
    grant = '0;
    if (alu_win)        grant = '{rdidx: alu_wbck_i_rdidx,   wdat: alu_wbck_i_wdat};
    else if (longp_win) grant = '{rdidx: longp_wbck_i_rdidx, wdat: longp_wbck_i_wdat};
  end

  // x0 writes are still acknowledged, they just never reach the regfile.
  assign rf_wbck_o_ena   = (alu_win | longp_win) & (grant.rdidx != '0);
  assign rf_wbck_o_wdat  = grant.wdat;
  assign rf_wbck_o_rdidx = grant.rdidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   starve_cnt <= '0;
    else if (alu_win)             starve_cnt <= '0;
    else if (conflict && !starved) starve_cnt <= starve_cnt + CW'(1);
  end

`ifdef E203_WBARB_SCOREBOARD_EN
  localparam int NREG = 1 << RFIDX_W;

  logic [NREG-1:1] pend_q, pend_nxt;
  logic [NREG-1:0] pending;

  assign pending = {pend_q, 1'b0};

  // Set is applied after clear so a same-index dispatch keeps the bit pending.
  always_comb begin
    pend_nxt = pend_q;
    for (int i = 1; i < NREG; i++) begin
      if (longp_win && longp_wbck_i_rdidx == RFIDX_W'(i)) pend_nxt[i] = 1'b0;
      if (disp_set_valid && disp_set_idx == RFIDX_W'(i))  pend_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_nxt;
  end

  assign dep_hazard = pending[dep_chk_idx1] | pending[dep_chk_idx2];
`else
  logic unused_scb;
  assign unused_scb = ^{disp_set_valid, disp_set_idx, dep_chk_idx1, dep_chk_idx2};
  assign dep_hazard = 1'b0;
`endif

endmodule
